// File: rtl/av_bridge_gen2.sv
`default_nettype none
// ============================================================================
// av_bridge_gen2 : CPU-to-peripheral bus bridge with programmable chip selects
// Rev 1.0
// ============================================================================
module av_bridge_gen2 #(
    parameter int          DW        = 32,
    parameter int          NCS       = 8,
    parameter logic [31:0] CFG_BASE  = 32'hFDFFF100,
    parameter logic [31:0] IO_BASE   = 32'hFD000000,
    parameter logic [31:0] CS_STRIDE = 32'h00100000,
    parameter logic [31:0] CS_MASK   = 32'hFFF00000,
    parameter logic [7:0]  TO_RESET  = 8'd255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            s_cyc_i,
    input  logic            s_stb_i,
    input  logic            s_we_i,
    input  logic [DW/8-1:0] s_sel_i,
    input  logic [31:0]     s_adr_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_ack_o,
    output logic            s_err_o,
    output logic [NCS-1:0]  cs_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic [31:0]     m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    input  logic [DW-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_stall_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        POST      = 2'd2,
        WAIT_NACK = 2'd3
    } state_t;

    state_t state, state_n;

    logic [31:0]    base [NCS];
    logic [31:0]    mask [NCS];
    logic           post_en;
    logic           wto;
    logic [7:0]     timeout;
    logic [7:0]     cnt;

    logic [NCS-1:0] hit;
    logic [NCS-1:0] cs_sel;
    logic           any_hit;

    logic           cfg_hit;
    logic           cfg_swap;
    logic [4:0]     cfg_idx;
    logic [31:0]    cfg_wdata;
    logic [31:0]    cfg_raw;
    logic [31:0]    cfg_rdata;
    logic [DW-1:0]  cfg_rd_ext;
    logic           cfg_wr;

    logic start, cfg_acc, bus_clr, ack_set, ack_drop, err_set, resp_clr, rd_cap, wto_set;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    assign cfg_hit   = (s_adr_i[31:8] == CFG_BASE[31:8]);
    assign cfg_swap  = s_adr_i[7];
    assign cfg_idx   = s_adr_i[6:2];
    assign cfg_wdata = cfg_swap ? bswap32(s_dat_i[31:0]) : s_dat_i[31:0];
    assign cfg_wr    = cfg_acc & s_we_i;

    generate
        for (genvar i = 0; i < NCS; i++) begin : g_dec
            assign hit[i] = (mask[i] != 32'h0) && (((s_adr_i ^ base[i]) & mask[i]) == 32'h0);
        end
    endgenerate

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        cs_sel  = '0;
        any_hit = 1'b0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                cs_sel    = '0;
                cs_sel[i] = 1'b1;
                any_hit   = 1'b1;
            end
        end
    end

    always_comb begin
        cfg_raw = 32'h0;
        for (int i = 0; i < NCS; i++) begin
            if (cfg_idx == {1'b0, 4'(i)}) cfg_raw = base[i];
            if (cfg_idx == {1'b1, 4'(i)}) cfg_raw = mask[i];
        end
        if (cfg_idx == 5'd31) cfg_raw = {16'h0, timeout, 6'h0, wto, post_en};
        cfg_rdata        = cfg_swap ? bswap32(cfg_raw) : cfg_raw;
        cfg_rd_ext       = '0;
        cfg_rd_ext[31:0] = cfg_rdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        cfg_acc  = 1'b0;
        bus_clr  = 1'b0;
        ack_set  = 1'b0;
        ack_drop = 1'b0;
        err_set  = 1'b0;
        resp_clr = 1'b0;
        rd_cap   = 1'b0;
        wto_set  = 1'b0;
        case (state)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    if (cfg_hit) begin
                        cfg_acc = 1'b1;
                        ack_set = 1'b1;
                        state_n = WAIT_NACK;
                    end else if (!any_hit) begin
                        err_set = 1'b1;
                        state_n = WAIT_NACK;
                    end else if (!m_stall_i) begin
                        start = 1'b1;
                        if (s_we_i && post_en) begin
                            ack_set = 1'b1;
                            state_n = POST;
                        end else begin
                            state_n = WAIT_ACK;
                        end
                    end
                end
            end
            WAIT_ACK: begin
                if (m_ack_i) begin
                    bus_clr = 1'b1;
                    ack_set = 1'b1;
                    rd_cap  = ~m_we_o;
                    state_n = WAIT_NACK;
                end else if (!s_cyc_i) begin
                    bus_clr = 1'b1;
                    state_n = IDLE;
                end else if (cnt == 8'd1) begin
                    bus_clr = 1'b1;
                    err_set = 1'b1;
                    state_n = WAIT_NACK;
                end
            end
            POST: begin
                if (!s_stb_i) ack_drop = 1'b1;
                if (m_ack_i || cnt == 8'd1) begin
                    bus_clr = 1'b1;
                    wto_set = ~m_ack_i;
                    // A posted ack still held by the CPU must see its strobe fall first
                    state_n = (s_ack_o && s_stb_i) ? WAIT_NACK : IDLE;
                end
            end
            WAIT_NACK: begin
                if (!s_stb_i) begin
                    resp_clr = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCS; i++) begin
                base[i] <= IO_BASE + CS_STRIDE * 32'(i);
                mask[i] <= CS_MASK;
            end
            post_en <= 1'b0;
            wto     <= 1'b0;
            timeout <= TO_RESET;
        end else begin
            if (cfg_wr) begin
                for (int i = 0; i < NCS; i++) begin
                    if (cfg_idx == {1'b0, 4'(i)}) base[i] <= cfg_wdata;
                    if (cfg_idx == {1'b1, 4'(i)}) mask[i] <= cfg_wdata;
                end
                if (cfg_idx == 5'd31) begin
                    post_en <= cfg_wdata[0];
                    timeout <= cfg_wdata[15:8];
                end
            end
            if (wto_set)                                          wto <= 1'b1;
            else if (cfg_wr && cfg_idx == 5'd31 && cfg_wdata[1]) wto <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            m_adr_o <= 32'h0;
            m_dat_o <= '0;
            cs_o    <= '0;
            cnt     <= 8'h0;
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            s_dat_o <= '0;
        end else begin
            if (start) begin
                m_cyc_o <= 1'b1;
                m_stb_o <= 1'b1;
                m_we_o  <= s_we_i;
                m_sel_o <= s_sel_i;
                m_adr_o <= s_adr_i;
                m_dat_o <= s_dat_i;
                cs_o    <= cs_sel;
                cnt     <= timeout;
            end else begin
                if (bus_clr) begin
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                    m_we_o  <= 1'b0;
                    m_sel_o <= '0;
                    m_adr_o <= 32'h0;
                    m_dat_o <= '0;
                    cs_o    <= '0;
                end
                // A zero count never reaches 1, which is what disables the timeout
                if ((state == WAIT_ACK || state == POST) && cnt != 8'h0) cnt <= cnt - 8'd1;
            end

            if (ack_set)                   s_ack_o <= 1'b1;
            else if (ack_drop || resp_clr) s_ack_o <= 1'b0;

            if (err_set)       s_err_o <= 1'b1;
            else if (resp_clr) s_err_o <= 1'b0;

            if (rd_cap)        s_dat_o <= m_dat_i;
            else if (cfg_acc)  s_dat_o <= s_we_i ? '0 : cfg_rd_ext;
            else if (resp_clr) s_dat_o <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_av_bridge_gen2.sv
`default_nettype none
// Directed testbench for av_bridge_gen2 (default parameters, DW=32, NCS=8).
module tb_av_bridge_gen2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
    logic [3:0]  s_sel_i = 4'h0;
    logic [31:0] s_adr_i = 32'h0, s_dat_i = 32'h0;
    logic [31:0] s_dat_o;
    logic        s_ack_o, s_err_o;
    logic [7:0]  cs_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = 32'h0;
    logic        m_ack_i = 1'b0, m_stall_i = 1'b0;

    int tests = 0;
    int fails = 0;

    av_bridge_gen2 dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o), .cs_o(cs_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_stall_i(m_stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_sel_i = 4'hF;
        s_adr_i = adr;  s_dat_i = dat;
    endtask

    task automatic idle;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; s_sel_i = 4'h0;
        s_adr_i = 32'h0; s_dat_i = 32'h0;
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("rst_ack", {31'h0, s_ack_o}, 32'h0);
        chk("rst_err", {31'h0, s_err_o}, 32'h0);
        chk("rst_cs",  {24'h0, cs_o}, 32'h0);
        chk("rst_cyc", {31'h0, m_cyc_o}, 32'h0);
        chk("rst_adr", m_adr_o, 32'h0);
        rst_ni = 1'b1;
        tick;

        // cs1 read, ack three cycles after the strobe
        req(1'b0, 32'hFD100004, 32'h0);
        tick;
        chk("rd_cs",  {24'h0, cs_o}, 32'h02);
        chk("rd_adr", m_adr_o, 32'hFD100004);
        chk("rd_stb", {31'h0, m_stb_o}, 32'h1);
        tick; tick;
        chk("rd_wait_ack", {31'h0, s_ack_o}, 32'h0);
        m_ack_i = 1'b1; m_dat_i = 32'hCAFEF00D;
        tick;
        m_ack_i = 1'b0; m_dat_i = 32'h0;
        chk("rd_ack", {31'h0, s_ack_o}, 32'h1);
        chk("rd_dat", s_dat_o, 32'hCAFEF00D);
        chk("rd_cyc_clr", {31'h0, m_cyc_o}, 32'h0);
        chk("rd_cs_clr", {24'h0, cs_o}, 32'h0);
        tick;
        chk("rd_ack_hold", {31'h0, s_ack_o}, 32'h1);
        idle;
        tick;
        chk("rd_ack_drop", {31'h0, s_ack_o}, 32'h0);
        chk("rd_dat_drop", s_dat_o, 32'h0);

        // Byte-swapped config alias
        req(1'b1, 32'hFDFFF180, 32'h12345678);
        tick;
        chk("cfgw_ack", {31'h0, s_ack_o}, 32'h1);
        chk("cfgw_nofwd", {31'h0, m_cyc_o}, 32'h0);
        idle; tick;
        req(1'b0, 32'hFDFFF100, 32'h0);
        tick;
        chk("cfgr_base0", s_dat_o, 32'h78563412);
        idle; tick;
        req(1'b0, 32'hFDFFF180, 32'h0);
        tick;
        chk("cfgr_swap", s_dat_o, 32'h12345678);
        idle; tick;
        req(1'b0, 32'h78563412, 32'h0);
        tick;
        chk("newbase_cs", {24'h0, cs_o}, 32'h01);
        m_ack_i = 1'b1;
        tick;
        m_ack_i = 1'b0;
        chk("newbase_ack", {31'h0, s_ack_o}, 32'h1);
        idle; tick;

        // Unmapped address
        req(1'b0, 32'h10000000, 32'h0);
        tick;
        chk("miss_err", {31'h0, s_err_o}, 32'h1);
        chk("miss_ack", {31'h0, s_ack_o}, 32'h0);
        chk("miss_cyc", {31'h0, m_cyc_o}, 32'h0);
        tick;
        chk("miss_hold", {31'h0, s_err_o}, 32'h1);
        idle; tick;
        chk("miss_clr", {31'h0, s_err_o}, 32'h0);

        // Timeout of 4 cycles
        req(1'b1, 32'hFDFFF17C, 32'h00000400);
        tick; idle; tick;
        req(1'b0, 32'hFD200000, 32'h0);
        tick;
        chk("to_cs", {24'h0, cs_o}, 32'h04);
        tick; tick; tick;
        chk("to_early", {31'h0, s_err_o}, 32'h0);
        chk("to_cyc_early", {31'h0, m_cyc_o}, 32'h1);
        tick;
        chk("to_err", {31'h0, s_err_o}, 32'h1);
        chk("to_cyc", {31'h0, m_cyc_o}, 32'h0);
        chk("to_noack", {31'h0, s_ack_o}, 32'h0);
        idle; tick;

        // Posted writes, held second write, write timeout flag
        req(1'b1, 32'hFDFFF17C, 32'h00000401);
        tick; idle; tick;
        req(1'b1, 32'hFD300010, 32'h0000AA55);
        tick;
        chk("post_ack", {31'h0, s_ack_o}, 32'h1);
        chk("post_stb", {31'h0, m_stb_o}, 32'h1);
        chk("post_cs", {24'h0, cs_o}, 32'h08);
        chk("post_dat", m_dat_o, 32'h0000AA55);
        idle; tick;
        chk("post_ack_drop", {31'h0, s_ack_o}, 32'h0);
        req(1'b1, 32'hFD300020, 32'h0000BEEF);
        tick;
        chk("post_held_ack", {31'h0, s_ack_o}, 32'h0);
        chk("post_held_adr", m_adr_o, 32'hFD300010);
        m_ack_i = 1'b1;
        tick;
        m_ack_i = 1'b0;
        chk("post_done_cyc", {31'h0, m_cyc_o}, 32'h0);
        tick;
        chk("post2_ack", {31'h0, s_ack_o}, 32'h1);
        chk("post2_adr", m_adr_o, 32'hFD300020);
        idle;
        tick; tick; tick;
        chk("post2_pending", {31'h0, m_cyc_o}, 32'h1);
        tick;
        chk("post2_to_cyc", {31'h0, m_cyc_o}, 32'h0);
        req(1'b0, 32'hFDFFF17C, 32'h0);
        tick;
        chk("wto_set", s_dat_o, 32'h00000403);
        idle; tick;
        req(1'b1, 32'hFDFFF17C, 32'h00000402);
        tick; idle; tick;
        req(1'b0, 32'hFDFFF17C, 32'h0);
        tick;
        chk("wto_clr", s_dat_o, 32'h00000400);
        idle; tick;

        // Abort in WAIT_ACK
        req(1'b0, 32'hFD100000, 32'h0);
        tick;
        chk("abort_start", {31'h0, m_cyc_o}, 32'h1);
        idle;
        tick;
        chk("abort_cyc", {31'h0, m_cyc_o}, 32'h0);
        chk("abort_noack", {31'h0, s_ack_o}, 32'h0);
        tick;
        chk("abort_noack2", {31'h0, s_ack_o}, 32'h0);

        // Ack and abort in the same cycle: ack wins
        req(1'b0, 32'hFD100008, 32'h0);
        tick;
        idle;
        m_ack_i = 1'b1; m_dat_i = 32'h5A5A0001;
        tick;
        m_ack_i = 1'b0; m_dat_i = 32'h0;
        chk("ackabort_ack", {31'h0, s_ack_o}, 32'h1);
        chk("ackabort_dat", s_dat_o, 32'h5A5A0001);
        tick;
        chk("ackabort_clr", {31'h0, s_ack_o}, 32'h0);

        // Stall holds IDLE, then asynchronous reset mid-cycle
        m_stall_i = 1'b1;
        req(1'b0, 32'hFD100000, 32'h0);
        tick;
        chk("stall_cyc", {31'h0, m_cyc_o}, 32'h0);
        m_stall_i = 1'b0;
        tick;
        chk("unstall_cyc", {31'h0, m_cyc_o}, 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_cyc", {31'h0, m_cyc_o}, 32'h0);
        chk("arst_cs", {24'h0, cs_o}, 32'h0);
        chk("arst_adr", m_adr_o, 32'h0);
        idle;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick;

        // Reset restores base[0]
        req(1'b0, 32'hFD000040, 32'h0);
        tick;
        chk("rstbase_cs", {24'h0, cs_o}, 32'h01);
        m_ack_i = 1'b1;
        tick;
        m_ack_i = 1'b0;
        idle; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/av_bridge_gen2.md
Name: av_bridge_gen2

Overview:
- Parametrised successor I/O bridge between the CPU bus (slave side) and a shared low-speed peripheral bus (master side).
- Registers every master-side signal and decodes NCS programmable chip selects, each with its own base and mask.
- Answers unmapped accesses with an error; enforces a bus timeout.
- Supports optional single-entry write posting, and hosts its own configuration register window.

Parameters:
DW, 32, data width (32 or 64)
NCS, 8, number of chip selects (1..15)
CFG_BASE, 32'hFDFFF100, base of 256-byte config window
IO_BASE, 32'hFD000000, reset base of cs[0]
CS_STRIDE, 32'h00100000, reset base of cs[i] = IO_BASE + i*CS_STRIDE
CS_MASK, 32'hFFF00000, reset mask of every cs
TO_RESET, 8'd255, reset timeout (cycles)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
s_cyc_i  in  1  CPU cycle
s_stb_i  in  1  CPU strobe
s_we_i  in  1  write enable
s_sel_i  in  DW/8  byte selects
s_adr_i  in  32  address
s_dat_i  in  DW  write data
s_dat_o  out  DW  read data
s_ack_o  out  1  acknowledge
s_err_o  out  1  error (unmapped or timeout)
cs_o  out  NCS  one-hot registered chip selects
m_cyc_o  out  1  master cycle
m_stb_o  out  1  master strobe
m_we_o  out  1  master write
m_sel_o  out  DW/8  master byte selects
m_adr_o  out  32  master address
m_dat_o  out  DW  master write data
m_dat_i  in  DW  master read data
m_ack_i  in  1  master acknowledge
m_stall_i  in  1  master stall

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; base[i]=IO_BASE+i*CS_STRIDE; mask[i]=CS_MASK; ctrl = {TO_RESET, post_en=0, wto=0}; state IDLE.
- Config window, CFG_BASE..+0xFF:
  - Offset 0x00+4i is base[i]; 0x40+4i is mask[i]; 0x7C is ctrl.
  - ctrl bits: [0] post_en; [1] wto, sticky, write-1-clears; [15:8] timeout.
  - Offset bit 7 set selects a byte-swapped alias of the same registers, for both read and write.
  - Unimplemented offsets read 0 and ignore writes.
  - Config access is never forwarded. s_ack_o rises one cycle after s_stb_i and holds until s_stb_i falls.
- Decode: hit[i] = mask[i]!=0 && ((s_adr_i^base[i])&mask[i])==0. The lowest hit index wins; cs_o is one-hot.
- Decode miss outside the config window: s_err_o rises one cycle later and holds until s_stb_i falls. No master cycle is started.
- States: IDLE, WAIT_ACK, POST, WAIT_NACK.
- IDLE:
  - Start condition: s_cyc_i&s_stb_i&hit&~m_stall_i.
  - On start, register m_cyc/stb=1, we/sel/adr/dat and cs_o on the next edge (latency 1). If m_stall_i=1, wait in IDLE.
  - Write with post_en=1: s_ack_o=1 on the same edge; go to POST. Otherwise go to WAIT_ACK.
- WAIT_ACK:
  - A timeout counter loads from ctrl.timeout on entry and decrements each cycle.
  - m_ack_i: clear the master bus and cs_o, capture s_dat_o=m_dat_i (reads), set s_ack_o=1, go to WAIT_NACK.
  - Counter reaches 0: clear the bus, set s_err_o=1, go to WAIT_NACK.
  - s_cyc_i low (abort): clear the bus, go to IDLE with no ack.
  - m_ack_i and abort in the same cycle: the ack wins.
- POST:
  - The master cycle continues independently. s_ack_o drops when s_stb_i is low.
  - m_ack_i: clear the bus, go to IDLE. Timeout: clear the bus, set wto, go to IDLE.
  - A new CPU request arriving in POST is held, with no ack, until IDLE.
- WAIT_NACK: when s_stb_i is low, s_ack_o=s_err_o=0 and s_dat_o=0; go to IDLE. A request is accepted from IDLE no earlier than the next cycle.
- s_ack_o and s_err_o are never both 1.
- The master bus never carries two outstanding cycles.
- timeout=0 disables the timeout.

Test Plan:
- Read 0xFD100004 (cs1 hit) with m_ack_i 3 cycles after m_stb_o and m_dat_i=0xCAFEF00D -> cs_o=8'h02, m_adr_o=0xFD100004, then s_ack_o=1 with s_dat_o=0xCAFEF00D until s_stb_i falls.
- Write 0x12345678 to CFG_BASE+0x80 (swapped base[0]), then read CFG_BASE+0x00 -> returns 0x78563412; a following access to 0x78563412 asserts cs_o[0].
- Access 0x10000000 (no hit) -> s_err_o=1 one cycle later, m_cyc_o stays 0.
- Set ctrl.timeout=4, read cs2 with no m_ack_i -> s_err_o=1 after 4 cycles in WAIT_ACK, m_cyc_o=0.
- Set post_en=1, write cs3 -> s_ack_o on the cycle m_stb_o rises; a second write issued before m_ack_i gets no ack until the first completes; withholding m_ack_i for longer than the timeout sets wto (read back ctrl bit1=1, write 1 clears it).
- Drop s_cyc_i mid WAIT_ACK -> m_cyc_o=0 next cycle and no s_ack_o. Assert rst_ni low mid-cycle -> all outputs 0 immediately.
